sort_frame_loader: RTL

Upstream feeder for the insertion-sort stage. It accepts 32-bit words over a valid/ready stream and buffers one frame of SIZE words. It then replays the frame into the sorter as a start-qualified burst of SIZE consecutive cycles, and paces itself on the sorter's done flag. It also provides a result-valid strobe aligned with the sorter's serial output, so downstream logic can capture sorted words without its own counting.

---
 rtl/sort_frame_loader_pkg.sv | 29 ++
 rtl/sort_frame_loader_buffer.sv | 42 ++++
 rtl/sort_frame_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sort_frame_loader_pkg.sv
// ---------------------------------------------------------------------------
// sort_frame_loader_pkg
//
// Shared definitions for the insertion-sort front end. The frame size lives
// here so that the loader and the sorter are always built with the same value.
//
// Contents:
//   DATA_W       word width carried on every data path
//   SORT_SIZE    words per frame (sorter `size`)
//   FRAME_CNT_W  default width of the completed-frame counter
//   word_t       one data word
//   ST_*         loader FSM state encodings
// ---------------------------------------------------------------------------
package sort_frame_loader_pkg;

    localparam int DATA_W      = 32;
    localparam int SORT_SIZE   = 8;
    localparam int FRAME_CNT_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    // Loader FSM encodings. FILL must stay 0: busy and the reset state
    // both depend on "not FILL" meaning "something is in flight".
    localparam logic [1:0] ST_FILL  = 2'd0;  // idle or collecting words
    localparam logic [1:0] ST_BURST = 2'd1;  // replaying the frame into the sorter
    localparam logic [1:0] ST_WAIT  = 2'd2;  // sorter busy, buffer may refill
    localparam logic [1:0] ST_DRAIN = 2'd3;  // sorter presenting sorted words

endpackage

// File: rtl/sort_frame_loader_buffer.sv
// ---------------------------------------------------------------------------
// sort_frame_loader_buffer
//
// SIZE x DATA_W register file holding one frame. One synchronous write port
// and one combinational read port. Contents are not reset: every entry is
// rewritten before a frame is replayed, so stale data is never observed.
//
// Ports:
//   clk        clock, writes on rising edge
//   wr_en_i    write strobe
//   wr_addr_i  write index, 0..SIZE-1
//   wr_data_i  write word
//   rd_addr_i  read index; indices >= SIZE read as zero
//   rd_data_o  read word (combinational)
// ---------------------------------------------------------------------------
module sort_frame_loader_buffer
    import sort_frame_loader_pkg::*;
#(
    parameter int SIZE = SORT_SIZE,
    parameter int IW   = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    word_t mem_q [SIZE];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The extra leading zero keeps the bound comparison exact even when SIZE
    // is a power of two and would not fit in IW bits.
    assign rd_data_o = ({1'b0, rd_addr_i} < (IW + 1)'(SIZE)) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/sort_frame_loader.sv
// ---------------------------------------------------------------------------
// sort_frame_loader
//
// Collects SIZE words from a valid/ready producer, replays them into the
// insertion sorter as a start-qualified burst of SIZE back-to-back cycles,
// waits for the sorter's done flag and then raises res_valid for exactly the
// SIZE cycles in which the sorter presents sorted words.
//
// Handshake: a word moves on a rising edge where in_valid && in_ready are both
// high. in_ready depends only on registered state (never on in_valid), so the
// producer may hold in_valid and in_data steady until the word is taken.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   in_valid     producer word valid
//   in_data      producer word
//   in_ready     loader can take a word this cycle (combinational)
//   sort_start   one-cycle pulse with the first burst word (sorter start)
//   sort_data    burst word (sorter inData)
//   sort_done    sorter done, only looked at in WAIT
//   res_valid    high while sorter outData holds a sorted word
//   busy         FSM is not in FILL
//   frame_count  completed frames, wraps
//   dbg_state    current FSM state (ST_* encoding)
// ---------------------------------------------------------------------------
module sort_frame_loader
    import sort_frame_loader_pkg::*;
#(
    parameter int SIZE  = SORT_SIZE,
    parameter int CNT_W = FRAME_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sort_start,
    output logic [DATA_W-1:0] sort_data,
    input  logic              sort_done,
    output logic              res_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(SIZE + 1);   // counters reach SIZE
    localparam int IW = $clog2(SIZE);       // buffer index

    localparam logic [CW-1:0] FULL = CW'(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]    dr_cnt_q, dr_cnt_d;
    logic             sort_start_q, sort_start_d;
    word_t            sort_data_q, sort_data_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;

    logic             wr_full;
    logic             accept;
    logic [IW-1:0]    rd_idx;
    word_t            rd_word;

    assign wr_full  = (wr_cnt_q == FULL);
    assign in_ready = (wr_cnt_q < FULL) && (state_q != ST_BURST);
    assign accept   = in_valid && in_ready;

    // The read port always looks one word ahead of what sort_data shows:
    // index 0 while waiting to start a burst, rd_cnt+1 during the burst.
    // On the last burst word the look-ahead index is unused.
    assign rd_idx = (state_q == ST_BURST) ? IW'(rd_cnt_q + CW'(1)) : '0;

    sort_frame_loader_buffer #(
        .SIZE (SIZE),
        .IW   (IW)
    ) u_buffer (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (IW'(wr_cnt_q)),
        .wr_data_i (in_data),
        .rd_addr_i (rd_idx),
        .rd_data_o (rd_word)
    );

    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        dr_cnt_d      = dr_cnt_q;
        sort_start_d  = 1'b0;
        sort_data_d   = sort_data_q;
        res_valid_d   = res_valid_q;
        frame_count_d = frame_count_q;

        // Accepts can happen in FILL, WAIT and DRAIN; in_ready already
        // excludes BURST and a full buffer, so this never collides with the
        // wr_cnt clear at the end of a burst.
        if (accept) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end

        case (state_q)
            ST_FILL: begin
                if (wr_full) begin
                    state_d      = ST_BURST;
                    rd_cnt_d     = '0;
                    sort_start_d = 1'b1;
                    sort_data_d  = rd_word;
                end
            end

            ST_BURST: begin
                if (rd_cnt_q == LAST) begin
                    // Whole frame handed over; the buffer is free to refill
                    // while the sorter works.
                    state_d  = ST_WAIT;
                    wr_cnt_d = '0;
                end else begin
                    rd_cnt_d    = rd_cnt_q + CW'(1);
                    sort_data_d = rd_word;
                end
            end

            ST_WAIT: begin
                if (sort_done) begin
                    state_d     = ST_DRAIN;
                    res_valid_d = 1'b1;
                    dr_cnt_d    = '0;
                end
            end

            ST_DRAIN: begin
                dr_cnt_d = dr_cnt_q + CW'(1);
                if (dr_cnt_q == LAST) begin
                    res_valid_d   = 1'b0;
                    frame_count_d = frame_count_q + CNT_W'(1);
                    // Start the next burst on this same edge when a full
                    // frame is waiting: the sorter's output phase ends here,
                    // so the new start cannot overlap res_valid.
                    if (wr_full) begin
                        state_d      = ST_BURST;
                        rd_cnt_d     = '0;
                        sort_start_d = 1'b1;
                        sort_data_d  = rd_word;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FILL;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            dr_cnt_q      <= '0;
            sort_start_q  <= 1'b0;
            sort_data_q   <= '0;
            res_valid_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            dr_cnt_q      <= dr_cnt_d;
            sort_start_q  <= sort_start_d;
            sort_data_q   <= sort_data_d;
            res_valid_q   <= res_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign sort_start  = sort_start_q;
    assign sort_data   = sort_data_q;
    assign res_valid   = res_valid_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != ST_FILL);
    assign dbg_state   = state_q;

endmodule
